jif_bus_bridge: RTL and testbench

//   Memory-side deserializer for the CPU-handler byte bus. Captures an NBYTES-byte address,

---
 rtl/jif_bus_pkg.sv | 40 ++++
 rtl/jif_frame_phase_counter.sv | 43 ++++
 rtl/jif_bus_bridge.sv | 130 +++++++++++++
 tb/tb_jif_bus_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jif_bus_pkg.sv
// ---------------------------------------------------------------------------
// jif_bus_pkg : shared types and phase helpers for the JIF byte-bus bridge
// ---------------------------------------------------------------------------
`default_nettype none

package jif_bus_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CAPTURE  = 3'd1,
      FLAG     = 3'd2,
      REQ      = 3'd3,
      READBACK = 3'd4
   } state_t;

   localparam logic RW_WRITE = 1'b1;

   function automatic int ph_flag(input int n);
      return n;
   endfunction

   function automatic int ph_req(input int n);
      return n + 1;
   endfunction

   function automatic int ph_rb0(input int n);
      return n + 2;
   endfunction

   function automatic int ph_last(input int n);
      return 2 * n + 1;
   endfunction

   function automatic int phase_width(input int n);
      return $clog2(2 * n + 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/jif_frame_phase_counter.sv
// ---------------------------------------------------------------------------
// jif_frame_phase_counter : tracks the frame phase; phase 0 is the frame_sync cycle
// ---------------------------------------------------------------------------
`default_nettype none

module jif_frame_phase_counter
   import jif_bus_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int PW     = phase_width(NBYTES)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_sync,
   output logic [PW-1:0] phase,
   output logic          active
);

   localparam logic [PW-1:0] PH_LAST_P = PW'(ph_last(NBYTES));

   logic          run_q;
   logic [PW-1:0] cnt_q;

   // While idle, a frame_sync cycle is itself phase 0; syncs during a run are ignored.
   assign active = run_q | frame_sync;
   assign phase  = run_q ? cnt_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (active && (phase != PH_LAST_P)) begin
         run_q <= 1'b1;
         cnt_q <= phase + 1'b1;
      end else begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/jif_bus_bridge.sv
// ---------------------------------------------------------------------------
// jif_bus_bridge : byte-lane deserializer, req/ack memory master, readback serializer
// ---------------------------------------------------------------------------
`default_nettype none

module jif_bus_bridge
   import jif_bus_pkg::*;
#(
   parameter int         NBYTES  = 4,
   parameter logic [7:0] RD_FILL = 8'h00
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_sync,
   input  logic [7:0]            bus_addr_in,
   input  logic [7:0]            bus_data_in,
   output logic [7:0]            bus_data_out,
   output logic                  bus_data_oe,
   output logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  mem_we,
   output logic [8*NBYTES-1:0]   mem_addr,
   output logic [8*NBYTES-1:0]   mem_wdata,
   input  logic [8*NBYTES-1:0]   mem_rdata,
   input  logic                  err_clr,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int            PW        = phase_width(NBYTES);
   localparam logic [PW-1:0] PH_FLAG_P = PW'(ph_flag(NBYTES));
   localparam logic [PW-1:0] PH_LAST_P = PW'(ph_last(NBYTES));

   logic [PW-1:0]       phase;
   logic                active;
   state_t              state_q, state_d;
   logic [8*NBYTES-1:0] addr_q, wdata_q, rdata_q;
   logic                we_q, req_q, rdata_vld, err_q;
   logic                capture_en, fill_err, timeout, err_set;

   jif_frame_phase_counter #(
      .NBYTES (NBYTES),
      .PW     (PW)
   ) u_phase (
      .clk        (clk),
      .rst        (rst),
      .frame_sync (frame_sync),
      .phase      (phase),
      .active     (active)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      bus_data_oe  = 1'b0;
      bus_data_out = 8'h00;
      fill_err     = 1'b0;
      case (state_q)
         IDLE:     if (frame_sync) state_d = (NBYTES > 1) ? CAPTURE : FLAG;
         CAPTURE:  if (phase == PH_FLAG_P - 1'b1) state_d = FLAG;
         FLAG:     state_d = REQ;
         REQ:      state_d = READBACK;
         READBACK: if (phase == PH_LAST_P) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // Read frames own the data lane for the whole readback window, even before data arrives.
      if (state_q == READBACK && we_q != RW_WRITE) begin
         bus_data_oe = 1'b1;
         fill_err    = ~rdata_vld;
         for (int j = 0; j < NBYTES; j++) begin
            if (phase == PW'(ph_rb0(NBYTES) + j))
               bus_data_out = rdata_vld ? rdata_q[8*j +: 8] : RD_FILL;
         end
      end
   end

   assign capture_en = (state_q == IDLE && frame_sync) || (state_q == CAPTURE);
   assign timeout    = req_q && !mem_ack && (state_q == READBACK) && (phase == PH_LAST_P);
   assign err_set    = (frame_sync && state_q != IDLE) || fill_err || timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         req_q     <= 1'b0;
         rdata_vld <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (capture_en) begin
            for (int k = 0; k < NBYTES; k++) begin
               if (phase == PW'(k)) begin
                  addr_q[8*k +: 8]  <= bus_addr_in;
                  wdata_q[8*k +: 8] <= bus_data_in;
               end
            end
         end
         if (state_q == IDLE && frame_sync) rdata_vld <= 1'b0;
         if (state_q == FLAG) begin
            we_q  <= bus_addr_in[0];
            req_q <= 1'b1;
         end
         if (req_q && mem_ack) begin
            rdata_q   <= mem_rdata;
            rdata_vld <= 1'b1;
            req_q     <= 1'b0;
         end else if (timeout) begin
            req_q <= 1'b0;
         end
         // A new error outranks a simultaneous clear so no event is lost.
         if (err_set)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign frame_err = err_q;
   assign busy      = active;

endmodule

`default_nettype wire

// File: tb/tb_jif_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_jif_bus_bridge : table-driven frame vectors plus back-to-back and reset sequences
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jif_bus_bridge;

   logic        clk = 1'b0;
   logic        rst, frame_sync, mem_ack, err_clr;
   logic [7:0]  bus_addr_in, bus_data_in, bus_data_out;
   logic        bus_data_oe, mem_req, mem_we, frame_err, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_ph;
      int          xsync_ph;
      int          clr_ph;
      logic [9:0]  req_mask;
      logic [31:0] rb;
      logic        err;
   } frame_t;

   frame_t vec [7];
   frame_t f1, f2, fr;

   jif_bus_bridge #(
      .NBYTES  (4),
      .RD_FILL (8'h00)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_sync   (frame_sync),
      .bus_addr_in  (bus_addr_in),
      .bus_data_in  (bus_data_in),
      .bus_data_out (bus_data_out),
      .bus_data_oe  (bus_data_oe),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .err_clr      (err_clr),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle(input logic clr);
      frame_sync  = 1'b0;
      mem_ack     = 1'b0;
      err_clr     = clr;
      bus_addr_in = 8'h00;
      bus_data_in = 8'h00;
      mem_rdata   = 32'h0;
   endtask

   task automatic drive(input frame_t f, input int p);
      int i;
      logic [31:0] a, d;
      i = p & 3;
      a = f.addr;
      d = f.wdata;
      frame_sync  = (p == 0) || (p == f.xsync_ph);
      bus_addr_in = (p < 4) ? a[8*i +: 8] : (p == 4) ? (8'hF0 | {7'b0, f.rw}) : 8'h3C;
      bus_data_in = (p < 4) ? d[8*i +: 8] : 8'hA5;
      mem_ack     = (p == f.ack_ph);
      mem_rdata   = (p == f.ack_ph) ? f.rdata : 32'h0BAD0BAD;
      err_clr     = (p == f.clr_ph);
   endtask

   task automatic run_frame(input frame_t f, input string tag);
      logic        exp_oe;
      logic [7:0]  exp_do;
      logic [31:0] rb;
      int          j;
      for (int p = 0; p < 10; p++) begin
         drive(f, p);
         @(negedge clk);
         rb     = f.rb;
         j      = (p >= 6) ? p - 6 : 0;
         exp_oe = !f.rw && (p >= 6);
         exp_do = exp_oe ? rb[8*j +: 8] : 8'h00;
         chk($sformatf("%s busy p%0d", tag, p), 32'(busy), 32'd1);
         chk($sformatf("%s mem_req p%0d", tag, p), 32'(mem_req), 32'(f.req_mask[p]));
         chk($sformatf("%s oe p%0d", tag, p), 32'(bus_data_oe), 32'(exp_oe));
         chk($sformatf("%s data_out p%0d", tag, p), 32'(bus_data_out), 32'(exp_do));
         if (p == 0) chk($sformatf("%s frame_err p0", tag), 32'(frame_err), 32'd0);
         if (p == 5) begin
            chk($sformatf("%s mem_addr", tag), mem_addr, f.addr);
            chk($sformatf("%s mem_wdata", tag), mem_wdata, f.wdata);
            chk($sformatf("%s mem_we", tag), 32'(mem_we), 32'(f.rw));
         end
         step();
      end
   endtask

   // Cycle after the last phase: check idle outputs, then clear the error flag.
   task automatic after_frame(input logic exp_err, input string tag);
      drive_idle(1'b1);
      @(negedge clk);
      chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
      chk($sformatf("%s idle mem_req", tag), 32'(mem_req), 32'd0);
      chk($sformatf("%s idle oe", tag), 32'(bus_data_oe), 32'd0);
      chk($sformatf("%s idle data_out", tag), 32'(bus_data_out), 32'd0);
      chk($sformatf("%s frame_err", tag), 32'(frame_err), 32'(exp_err));
      step();
      drive_idle(1'b0);
      @(negedge clk);
      chk($sformatf("%s frame_err cleared", tag), 32'(frame_err), 32'd0);
      step();
   endtask

   initial begin
      //          rw    addr          wdata         rdata         ack xs  clr mask         rb            err
      vec[0] = '{1'b1, 32'h12345678, 32'hDEADBEEF, 32'h0,       5,  -1, -1, 10'h020, 32'h00000000, 1'b0};
      vec[1] = '{1'b0, 32'h80001000, 32'h00000000, 32'hCAFEF00D, 5,  -1, -1, 10'h020, 32'hCAFEF00D, 1'b0};
      vec[2] = '{1'b0, 32'h00000044, 32'h11111111, 32'h11223344, 7,  -1, -1, 10'h0E0, 32'h11220000, 1'b1};
      vec[3] = '{1'b1, 32'hFFFFFFFF, 32'h01020304, 32'h0,       -1, -1, -1, 10'h3E0, 32'h00000000, 1'b1};
      vec[4] = '{1'b1, 32'h0000BEEF, 32'h5A5A5A5A, 32'h0,       9,  -1, -1, 10'h3E0, 32'h00000000, 1'b0};
      vec[5] = '{1'b0, 32'h13572468, 32'h00000000, 32'h99887766, 6,  -1,  6, 10'h060, 32'h99887700, 1'b1};
      vec[6] = '{1'b1, 32'hA1B2C3D4, 32'h0F1E2D3C, 32'h0,       5,   3, -1, 10'h020, 32'h00000000, 1'b1};
      f1 = '{1'b0, 32'h00C0FFEE, 32'h0, 32'hAABBCCDD, 5, -1, -1, 10'h020, 32'hAABBCCDD, 1'b0};
      f2 = '{1'b0, 32'h00000BAD, 32'h0, 32'h55667788, 8, -1, -1, 10'h1E0, 32'h55000000, 1'b1};
      fr = '{1'b0, 32'h01020304, 32'h05060708, 32'h0, -1, -1, -1, 10'h3E0, 32'h0, 1'b0};

      rst = 1'b1;
      drive_idle(1'b0);
      step();
      step();
      @(negedge clk);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      chk("reset oe", 32'(bus_data_oe), 32'd0);
      chk("reset data_out", 32'(bus_data_out), 32'd0);
      chk("reset frame_err", 32'(frame_err), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      step();

      for (int v = 0; v < 7; v++) begin
         run_frame(vec[v], $sformatf("vec%0d", v));
         after_frame(vec[v].err, $sformatf("vec%0d", v));
      end

      // Back-to-back: frame 2 must not see frame-1 read data before its own ack.
      run_frame(f1, "b2b_f1");
      run_frame(f2, "b2b_f2");
      after_frame(1'b1, "b2b");

      // Reset in phase 6 of a read with the request still pending.
      for (int p = 0; p < 6; p++) begin
         drive(fr, p);
         step();
      end
      drive(fr, 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive_idle(1'b0);
      @(negedge clk);
      chk("rst_mid mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid mem_we", 32'(mem_we), 32'd0);
      chk("rst_mid mem_addr", mem_addr, 32'd0);
      chk("rst_mid mem_wdata", mem_wdata, 32'd0);
      chk("rst_mid oe", 32'(bus_data_oe), 32'd0);
      chk("rst_mid data_out", 32'(bus_data_out), 32'd0);
      chk("rst_mid frame_err", 32'(frame_err), 32'd0);
      chk("rst_mid busy", 32'(busy), 32'd0);
      step();
      run_frame(vec[1], "post_rst");
      after_frame(1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
